// File: rtl/credit_pkg.sv
// Shared credit-link definitions for credit_sender, credit_counter and credit_wrapper.
package credit_pkg;

    localparam int CREDIT_DEFAULT = 16;

    // Bits needed to hold 0..n inclusive.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [credit_width(CREDIT_DEFAULT)-1:0] credit_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter starting full at N_CREDITS; also usable as a FIFO occupancy tracker.
// CREDIT_SENDER_CHECK_EN selects saturation at N_CREDITS on overflow.
module credit_counter
    import credit_pkg::*;
#(
    parameter int N_CREDITS = CREDIT_DEFAULT,
    parameter int CW        = credit_width(N_CREDITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] FULL = CW'(N_CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;

    // A simultaneous spend absorbs the returned credit, so only a lone inc can overflow.
    assign overflow_o = inc_i & ~dec_i & (cnt_q == FULL);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - 1'b1;
        end
`ifdef CREDIT_SENDER_CHECK_EN
        if (overflow_o) begin
            cnt_d = FULL;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= FULL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/credit_sender.sv
// Transmit end of the credit link: launches producer words only while holding a credit.
// Optional CREDIT_SENDER_CHECK_EN adds a sticky overflow error flag and assertion.
module credit_sender
    import credit_pkg::*;
#(
    parameter  int DATA_WIDTH = 17,
    parameter  int N_CREDITS  = CREDIT_DEFAULT,
    localparam int CW         = credit_width(N_CREDITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_increment_count,
    output logic [CW-1:0]         o_credits,
    output logic                  o_error
);

    logic [CW-1:0]         cnt;
    logic                  overflow;
    logic                  send;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    credit_counter #(
        .N_CREDITS (N_CREDITS),
        .CW        (CW)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .inc_i      (i_increment_count),
        .dec_i      (send),
        .count_o    (cnt),
        .overflow_o (overflow)
    );

    // Ready depends only on the registered count, so a credit returned at zero is spendable next cycle.
    assign o_ready = (cnt != '0);
    assign send    = i_valid & o_ready;

    always_comb begin
        valid_d = send;
        data_d  = data_q;
        if (send) begin
            data_d = i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_credits = cnt;

`ifdef CREDIT_SENDER_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q | overflow;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign o_error = error_q;

    ovf_chk: assert property (@(posedge clock) disable iff (!reset) !overflow)
        else $warning("credit_sender: credit returned while already full");
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign o_error         = 1'b0;
`endif

endmodule

// File: tb/tb_credit_sender.sv
// Self-checking bench for credit_sender: directed vector table, corner sequences, random link model.
module tb_credit_sender;

    localparam int N  = 4;
    localparam int DW = 17;
    localparam int CW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_increment_count = 1'b0;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_credits;
    logic          o_error;

    credit_sender #(.DATA_WIDTH(DW), .N_CREDITS(N)) dut (
        .clock             (clock),
        .reset             (reset),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .o_ready           (o_ready),
        .o_valid           (o_valid),
        .o_data            (o_data),
        .i_increment_count (i_increment_count),
        .o_credits         (o_credits),
        .o_error           (o_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic          v;
        logic          inc;
        logic [DW-1:0] d;
        logic          ev;
        logic [CW-1:0] ec;
        logic          er;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic inc, input int d, input logic ev,
                       input int ec, input logic er, input int ed);
        vec_t r;
        r.v = v; r.inc = inc; r.d = DW'(d); r.ev = ev; r.ec = CW'(ec); r.er = er; r.ed = DW'(ed);
        tbl.push_back(r);
    endtask

    // Random-phase word sequence: 1..0x7D0 then 0x1FC00..0x1FFFF.
    function automatic logic [DW-1:0] succ(input logic [DW-1:0] x);
        logic [DW-1:0] jump_from;
        jump_from = 17'h007D0;
        return (x == jump_from) ? 17'h1FC00 : x + 1'b1;
    endfunction

    initial begin
        // Expected after-edge outputs: valid, credits, ready, data (held when not valid).
        add(1, 0, 'h100, 1, 3, 1, 'h100);
        add(1, 0, 'h101, 1, 2, 1, 'h101);
        add(1, 0, 'h102, 1, 1, 1, 'h102);
        add(1, 0, 'h103, 1, 0, 0, 'h103);
        add(1, 0, 'h104, 0, 0, 0, 'h103);
        add(1, 1, 'h105, 0, 1, 1, 'h103);
        add(1, 0, 'h106, 1, 0, 0, 'h106);
        add(0, 1, 'h107, 0, 1, 1, 'h106);
        add(0, 1, 'h108, 0, 2, 1, 'h106);
        for (int i = 9; i < 19; i++) add(1, 1, 'h100 + i, 1, 2, 1, 'h100 + i);
        add(0, 1, 'h113, 0, 3, 1, 'h112);
        add(0, 1, 'h114, 0, 4, 1, 'h112);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_credits", o_credits, N);
        check("rst_error", o_error, 0);
        check("rst_ready", o_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        // Directed table: drain, starved return, spend+return steady state, refill
        foreach (tbl[k]) begin
            i_valid = tbl[k].v;
            i_increment_count = tbl[k].inc;
            i_data = tbl[k].d;
            step();
            check($sformatf("tbl%0d_valid", k), o_valid, tbl[k].ev);
            check($sformatf("tbl%0d_credits", k), o_credits, tbl[k].ec);
            check($sformatf("tbl%0d_ready", k), o_ready, tbl[k].er);
            check($sformatf("tbl%0d_data", k), o_data, tbl[k].ed);
        end
        i_valid = 1'b0;
        i_increment_count = 1'b0;

        // Overflow: credit returned while full
        i_increment_count = 1'b1;
        step();
        i_increment_count = 1'b0;
`ifdef CREDIT_SENDER_CHECK_EN
        check("ovf_error", o_error, 1);
        check("ovf_credits", o_credits, N);
        step();
        check("ovf_error_sticky", o_error, 1);
        check("ovf_credits_hold", o_credits, N);
`else
        check("ovf_error_off", o_error, 0);
        step();
        check("ovf_error_off2", o_error, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ovf_rst_error", o_error, 0);
        check("ovf_rst_credits", o_credits, N);
        @(negedge clock);
        reset = 1'b1;

        // Reset mid-stream at one remaining credit
        i_valid = 1'b1;
        for (int k = 0; k < N - 1; k++) begin
            i_data = DW'(32'hAA0 + k);
            step();
        end
        check("mid_credits", o_credits, 1);
        check("mid_valid", o_valid, 1);
        i_data = 17'h15555;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_credits", o_credits, N);
        check("midrst_ready", o_ready, 1);
        check("midrst_data", o_data, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("resume_valid", o_valid, 1);
        check("resume_data", o_data, 17'h15555);
        check("resume_credits", o_credits, N - 1);
        i_valid = 1'b0;

        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #4;

        // Random traffic through an N-deep receiver FIFO model
        begin
            int            cred;
            int            cyc;
            bit            pred_v, done, all_sent, v, inc, snd;
            logic [DW-1:0] pred_d, wnext, expo, last_w;
            logic [DW-1:0] rx_q[$];
            cred = N; pred_v = 0; pred_d = '0; wnext = 17'h1; expo = 17'h1;
            last_w = 17'h1FFFF; done = 0; all_sent = 0; cyc = 0;
            while (!done && cyc < 20000) begin
                inc = (rx_q.size() > 0) && ($urandom_range(2) == 0);
                if (inc) void'(rx_q.pop_front());
                v = !all_sent && ($urandom_range(3) != 0);
                i_valid = v;
                i_data = wnext;
                i_increment_count = inc;
                check("rnd_ready", o_ready, (cred > 0) ? 1 : 0);
                snd = v && (cred > 0);
                cred = cred + int'(inc) - int'(snd);
                pred_v = snd;
                if (snd) begin
                    pred_d = wnext;
                    if (wnext == last_w) all_sent = 1;
                    wnext = succ(wnext);
                end
                step();
                cyc++;
                check("rnd_valid", o_valid, pred_v);
                check("rnd_credits", o_credits, cred);
                check("rnd_data", o_data, pred_d);
                if (o_valid) begin
                    check("rnd_order", o_data, expo);
                    rx_q.push_back(o_data);
                    check("rnd_fifo_bound", (rx_q.size() <= N) ? 1 : 0, 1);
                    if (o_data == last_w) done = 1;
                    expo = succ(expo);
                end
            end
            i_valid = 1'b0;
            i_increment_count = 1'b0;
            if (!done) begin
                n_checks++;
                $display("FAIL rnd_timeout: last expected word %0h not received in %0d cycles", last_w, cyc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
